gamma_stream_coder: RTL and testbench
=====================================

GAMMA_STREAM_CODER -- requirements
Module: gamma_stream_coder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width.
REQ-002 SHALL have parameter LFSR_W, default 16: gamma generator width; LFSR_W >= WIDTH.
REQ-003 SHALL have parameter POLY, default 16'hB400: Galois feedback mask, LFSR_W bits.
REQ-004 SHALL have parameter SEED, default 16'hACE1: reset and fallback seed; must be nonzero.
REQ-005 SHALL have parameter CNT_W, default 16: word counter width.
REQ-006 SHALL use one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock; res_n  in  1  async reset, active low.
REQ-007 en  in  1  run enable.
REQ-008 mode  in  2  per-word op: 00 XOR, 01 ADD, 10 SUB, 11 bypass.
REQ-009 inp_valid  in  1, inp_ready  out  1, inp_data  in  WIDTH: input word handshake.
REQ-010 out_valid  out  1, out_ready  in  1, out_data  out  WIDTH+1: coded word; bit WIDTH is carry or borrow.
REQ-011 seed_ld  in  1, seed_data  in  LFSR_W: reseed request and new seed.
REQ-012 word_cnt  out  CNT_W: words accepted since reset or last reseed.

Function
REQ-013 FSM states SHALL be IDLE, RUN and RESEED; reset state is IDLE.
REQ-014 IDLE->RUN SHALL occur when en=1; RUN->IDLE when en=0 and seed_ld=0.
REQ-015 IDLE or RUN ->RESEED SHALL occur when seed_ld=1; RESEED SHALL last exactly one cycle, then go to RUN if en=1, else IDLE.
REQ-016 In RESEED, lfsr SHALL load seed_data, or SEED if seed_data==0, and word_cnt SHALL clear to 0.
REQ-017 inp_ready SHALL equal (state==RUN) & en & ~seed_ld & (~out_valid | out_ready); seed_ld has priority over a same-cycle input handshake.
REQ-018 A word is accepted when inp_valid & inp_ready; gamma g = lfsr[WIDTH-1:0] before the step.
REQ-019 On accept the LFSR SHALL step once (Galois, right shift): lsb=lfsr[0]; lfsr = (lfsr>>1) ^ (lsb ? POLY : 0); it SHALL NOT step otherwise.
REQ-020 Result on accept: XOR {1'b0, d^g}; ADD d+g as an unsigned WIDTH+1 sum; SUB {borrow, (d-g) mod 2^WIDTH} with borrow = (d<g); bypass {1'b0, d}. mode is sampled with the word.
REQ-021 out_data/out_valid SHALL be registered: latency 1 cycle from accept to out_valid=1, with full throughput of 1 word/cycle while out_ready=1.
REQ-022 out_valid SHALL clear on out_valid & out_ready with no new accept; out_data SHALL hold stable while out_valid & ~out_ready.
REQ-023 A pending output SHALL survive transitions to IDLE or RESEED and drain normally.
REQ-024 word_cnt SHALL increment by 1 per accept, wrap from 2^CNT_W-1 to 0, and clear in RESEED; the clear wins over the increment.
REQ-025 Decoding SHALL be achievable by an identical instance with the same seed: XOR inverts XOR, and SUB on the low WIDTH bits inverts ADD.

Reset
REQ-026 On res_n=0, immediately and without clk: state=IDLE, lfsr=SEED, out_valid=0, out_data=0, word_cnt=0, inp_ready=0.
REQ-027 Reset release mid-stream SHALL drop any in-flight word; no output appears for a word accepted before reset.

Verification (WIDTH=8, LFSR_W=16, defaults)
REQ-028 Reset, en=1, XOR, inp_data=8'h00, out_ready=1 -> out_data=9'h0E1 one cycle after accept; the second word 8'h00 -> 9'h070; word_cnt=2.
REQ-029 Reset, ADD, first word 8'h30 -> 9'h111; reset, SUB, first word 8'h11 -> 9'h130 (borrow=1).
REQ-030 out_ready=0 with out_valid=1 -> inp_ready=0, out_data stable, lfsr unchanged; release -> the next word uses gamma 8'h70.
REQ-031 seed_ld=1 with seed_data=16'h0000 in the same cycle as inp_valid -> no accept; next cycle lfsr=16'hACE1, word_cnt=0; next XOR 8'h00 -> 9'h0E1.
REQ-032 Encoder chain of 300 random words in ADD mode -> decoder in SUB mode, same seed, recovers every word; word_cnt=300; CNT_W=8 variant wraps to 44.
REQ-033 Assert res_n=0 asynchronously mid-burst -> all outputs reach reset values before the next clk edge.

Source files
------------

// File: rtl/gamma_stream_coder.sv
`default_nettype none
// ============================================================================
// Module      : gamma_stream_coder
// Description : Streaming gamma (keystream) coder. Each accepted word is
//               combined with the low bits of a Galois LFSR using XOR, ADD,
//               SUB or bypass. The result is registered with valid/ready
//               flow control. Supports reseeding and counts accepted words.
// Revision    : 1.0 - initial release
// ============================================================================
module gamma_stream_coder #(
    parameter int                WIDTH  = 8,
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] POLY   = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED   = 16'hACE1,
    parameter int                CNT_W  = 16
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic              inp_valid,
    output logic              inp_ready,
    input  logic [WIDTH-1:0]  inp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH:0]    out_data,
    input  logic              seed_ld,
    input  logic [LFSR_W-1:0] seed_data,
    output logic [CNT_W-1:0]  word_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_RESEED = 2'd2
    } state_t;

    localparam logic [1:0] C_MODE_XOR = 2'b00;
    localparam logic [1:0] C_MODE_ADD = 2'b01;
    localparam logic [1:0] C_MODE_SUB = 2'b10;

    state_t            state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH:0]    out_data_q, out_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              w_accept;
    logic              w_reseed;
    logic [WIDTH-1:0]  w_gamma;
    logic [WIDTH:0]    w_sum;
    logic [WIDTH:0]    w_diff;
    logic [WIDTH:0]    w_result;
    logic [LFSR_W-1:0] w_lfsr_step;
    logic [LFSR_W-1:0] w_new_seed;

    // A reseed request blocks input so the old keystream is never mixed with the new one.
    assign inp_ready = (state_q == ST_RUN) & en & ~seed_ld & (~out_valid_q | out_ready);
    assign w_accept  = inp_valid & inp_ready;

    // The reseed load happens on entry to RESEED, so RESEED already shows the new seed.
    assign w_reseed  = (state_d == ST_RESEED);

    assign w_gamma     = lfsr_q[WIDTH-1:0];
    assign w_lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : '0);
    assign w_new_seed  = (seed_data == '0) ? SEED : seed_data;

    // A zero-extended WIDTH+1 subtraction leaves the borrow (d < g) in the top bit.
    assign w_sum  = {1'b0, inp_data} + {1'b0, w_gamma};
    assign w_diff = {1'b0, inp_data} - {1'b0, w_gamma};

    // Per-word operation selected by the mode sampled with the word.
    always_comb begin
        w_result = {1'b0, inp_data};
        case (mode)
            C_MODE_XOR: w_result = {1'b0, inp_data ^ w_gamma};
            C_MODE_ADD: w_result = w_sum;
            C_MODE_SUB: w_result = w_diff;
            default:    w_result = {1'b0, inp_data};
        endcase
    end

    // Next-state logic: reseed takes priority over run/idle transitions.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (seed_ld)  state_d = ST_RESEED;
                else if (en)  state_d = ST_RUN;
            end
            ST_RUN: begin
                if (seed_ld)  state_d = ST_RESEED;
                else if (!en) state_d = ST_IDLE;
            end
            ST_RESEED: begin
                state_d = en ? ST_RUN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: keystream, output register and word counter.
    always_comb begin
        lfsr_d      = lfsr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        cnt_d       = cnt_q;

        if (w_reseed) begin
            lfsr_d = w_new_seed;
        end else if (w_accept) begin
            lfsr_d = w_lfsr_step;
        end

        if (w_reseed) begin
            cnt_d = '0;
        end else if (w_accept) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // A pending output is kept across IDLE/RESEED until the sink takes it.
        if (w_accept) begin
            out_valid_d = 1'b1;
            out_data_d  = w_result;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q     <= ST_IDLE;
            lfsr_q      <= SEED;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign word_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_gamma_stream_coder.sv
`default_nettype none
// ============================================================================
// Module      : tb_gamma_stream_coder
// Description : Directed and random stimulus for gamma_stream_coder with a
//               queue scoreboard fed by an independent keystream model, plus
//               an ADD encoder -> SUB decoder chain.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gamma_stream_coder;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] POLY = 16'hB400;

    logic        clk = 1'b0;
    logic        res_n = 1'b0;

    // main instance
    logic        en = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        inp_valid = 1'b0;
    logic        inp_ready;
    logic [7:0]  inp_data = 8'h00;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [8:0]  out_data;
    logic        seed_ld = 1'b0;
    logic [15:0] seed_data = 16'h0000;
    logic [15:0] word_cnt;

    // chain: encoder (8-bit counter) feeding decoder
    logic        c_valid = 1'b0;
    logic [7:0]  c_data = 8'h00;
    logic        e_ready, e_ov, d_ready, d_ov;
    logic [8:0]  e_od, d_od;
    logic [7:0]  e_cnt;
    logic [15:0] d_cnt;

    int          total = 0;
    int          bad = 0;
    logic [8:0]  q[$];
    logic [7:0]  cq[$];
    logic [15:0] m_lfsr = SEED;

    always #5 clk = ~clk;

    gamma_stream_coder dut (
        .clk(clk), .res_n(res_n), .en(en), .mode(mode),
        .inp_valid(inp_valid), .inp_ready(inp_ready), .inp_data(inp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .seed_ld(seed_ld), .seed_data(seed_data), .word_cnt(word_cnt)
    );

    gamma_stream_coder #(.CNT_W(8)) u_enc (
        .clk(clk), .res_n(res_n), .en(1'b1), .mode(2'b01),
        .inp_valid(c_valid), .inp_ready(e_ready), .inp_data(c_data),
        .out_valid(e_ov), .out_ready(d_ready), .out_data(e_od),
        .seed_ld(1'b0), .seed_data(16'h0000), .word_cnt(e_cnt)
    );

    gamma_stream_coder u_dec (
        .clk(clk), .res_n(res_n), .en(1'b1), .mode(2'b10),
        .inp_valid(e_ov), .inp_ready(d_ready), .inp_data(e_od[7:0]),
        .out_valid(d_ov), .out_ready(1'b1), .out_data(d_od),
        .seed_ld(1'b0), .seed_data(16'h0000), .word_cnt(d_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] model_res(input logic [1:0] m, input logic [7:0] d,
                                             input logic [7:0] g);
        logic [7:0] diff;
        diff = d - g;
        case (m)
            2'b00:   return {1'b0, d ^ g};
            2'b01:   return {1'b0, d} + {1'b0, g};
            2'b10:   return {(d < g), diff};
            default: return {1'b0, d};
        endcase
    endfunction

    function automatic logic [15:0] model_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? POLY : 16'h0000);
    endfunction

    // Scoreboard: push on input handshake, pop/compare on output handshake.
    always @(negedge clk) begin
        logic [8:0] e;
        logic [7:0] ce;
        if (!res_n) begin
            q.delete();
            cq.delete();
            m_lfsr = SEED;
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("sb_unexpected", 32'd1, 32'd0);
                else begin
                    e = q.pop_front();
                    chk("sb_data", out_data, e);
                end
            end
            if (inp_valid && inp_ready) begin
                q.push_back(model_res(mode, inp_data, m_lfsr[7:0]));
                m_lfsr = model_step(m_lfsr);
            end
            if (seed_ld) m_lfsr = (seed_data != 16'h0000) ? seed_data : SEED;
            if (c_valid && e_ready) cq.push_back(c_data);
            if (d_ov) begin
                if (cq.size() == 0) chk("chain_unexpected", 32'd1, 32'd0);
                else begin
                    ce = cq.pop_front();
                    chk("chain_data", d_od[7:0], ce);
                end
            end
        end
    end

    task automatic send(input logic [1:0] m, input logic [7:0] d);
        int n;
        n = 0;
        mode = m;
        inp_data = d;
        inp_valid = 1'b1;
        @(negedge clk);
        while (!inp_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", inp_ready, 1'b1);
        @(posedge clk); #1;
        inp_valid = 1'b0;
    endtask

    task automatic rst_pulse();
        @(posedge clk); #1;
        res_n = 1'b0;
        @(posedge clk); #1;
        res_n = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || cq.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_q", q.size(), 0);
        chk("drain_cq", cq.size(), 0);
    endtask

    initial begin
        int n;
        // reset values while reset is held
        #1;
        chk("rst_inp_ready", inp_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 9'h000);
        chk("rst_word_cnt", word_cnt, 16'h0000);
        @(posedge clk); #1;
        res_n = 1'b1;

        // XOR of zero words exposes the raw keystream
        en = 1'b1;
        out_ready = 1'b1;
        send(2'b00, 8'h00);
        chk("xor_w0", out_data, 9'h0E1);
        chk("xor_w0_valid", out_valid, 1'b1);
        send(2'b00, 8'h00);
        chk("xor_w1", out_data, 9'h070);
        chk("xor_cnt", word_cnt, 16'd2);

        // ADD and SUB first words after reset
        rst_pulse();
        send(2'b01, 8'h30);
        chk("add_w0", out_data, 9'h111);
        rst_pulse();
        send(2'b10, 8'h11);
        chk("sub_w0", out_data, 9'h130);

        // back-pressure: output held, no accept, keystream frozen
        rst_pulse();
        out_ready = 1'b0;
        send(2'b00, 8'h00);
        inp_valid = 1'b1;
        inp_data = 8'h55;
        repeat (3) begin
            @(negedge clk);
            chk("bp_inp_ready", inp_ready, 1'b0);
            chk("bp_out_data", out_data, 9'h0E1);
            chk("bp_out_valid", out_valid, 1'b1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(2'b00, 8'h55);
        chk("bp_next_gamma", out_data, 9'h025);

        // reseed with zero falls back to SEED and beats a same-cycle input
        seed_ld = 1'b1;
        seed_data = 16'h0000;
        inp_valid = 1'b1;
        inp_data = 8'h00;
        mode = 2'b00;
        @(negedge clk);
        chk("reseed_block", inp_ready, 1'b0);
        @(posedge clk); #1;
        seed_ld = 1'b0;
        inp_valid = 1'b0;
        @(negedge clk);
        chk("reseed_cnt", word_cnt, 16'd0);
        chk("reseed_rdy", inp_ready, 1'b0);
        send(2'b00, 8'h00);
        chk("reseed_w0", out_data, 9'h0E1);

        // asynchronous reset in the middle of a burst
        @(posedge clk); #1;
        mode = 2'b01;
        inp_valid = 1'b1;
        inp_data = 8'($urandom);
        repeat (5) begin
            @(posedge clk); #1;
            inp_data = 8'($urandom);
        end
        chk("burst_active", out_valid, 1'b1);
        #2;
        res_n = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 1'b0);
        chk("async_out_data", out_data, 9'h000);
        chk("async_word_cnt", word_cnt, 16'h0000);
        chk("async_inp_ready", inp_ready, 1'b0);
        inp_valid = 1'b0;
        @(posedge clk); #1;
        res_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_stale_out", out_valid, 1'b0);

        // nonzero reseed, then random modes with random back-pressure
        @(posedge clk); #1;
        seed_ld = 1'b1;
        seed_data = 16'h1234;
        @(posedge clk); #1;
        seed_ld = 1'b0;
        for (int i = 0; i < 80; i++) begin
            inp_valid = 1'($urandom);
            mode = 2'($urandom);
            inp_data = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        inp_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // en low returns to IDLE: no acceptance
        en = 1'b0;
        inp_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_ready", inp_ready, 1'b0);
        @(posedge clk); #1;
        inp_valid = 1'b0;

        // encoder (ADD) -> decoder (SUB) chain, 300 words
        rst_pulse();
        for (int i = 0; i < 300; i++) begin
            c_valid = 1'b1;
            c_data = 8'($urandom);
            n = 0;
            @(negedge clk);
            while (!e_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (!e_ready) chk("chain_ready", e_ready, 1'b1);
            @(posedge clk); #1;
        end
        c_valid = 1'b0;
        n = 0;
        while (d_cnt != 16'd300 && n < 100) begin
            @(negedge clk);
            n++;
        end
        drain();
        chk("chain_dec_cnt", d_cnt, 16'd300);
        chk("chain_enc_cnt8", e_cnt, 8'd44);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
